motoro3_pwm_capture: RTL and testbench

Measures the high and low phase lengths of a PWM waveform in 10 MHz clock cycles and reports each complete period as an on-time/off-time pair with a one-cycle valid strobe. It is the receiving end of the motor PWM path. It sits on the gate-drive feedback line to check the waveform the PWM generator actually produced, and it also decodes externally supplied PWM commands. It also flags a line that is stuck high or stuck low.

---
 rtl/motoro3_pkg.sv | 24 ++
 rtl/motoro3_sync_edge.sv | 38 +++
 rtl/motoro3_pwm_capture.sv | 152 +++++++++++++++
 tb/tb_motoro3_pwm_capture.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// rtl/motoro3_pkg.sv - shared widths, saturation constants and state type for the PWM capture block
// Contents:
//   CNT_W      counter and result width
//   CNT_MAX    saturation value of every phase counter
//   capState_t capture state machine encoding
//   satInc     saturating increment used by both phase counters
package motoro3_pkg;

   localparam int CNT_W = 13;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } capState_t;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

endpackage

// File: rtl/motoro3_sync_edge.sv
// rtl/motoro3_sync_edge.sv - pwmIn synchronizer with registered edge detection
// Ports:
//   clk    in   system clock
//   nRst   in   asynchronous active-low reset
//   pwmIn  in   PWM line, asynchronous to clk
//   pwmS   out  synchronized PWM level
//   rise   out  pwmS went 0 -> 1 this cycle
//   fall   out  pwmS went 1 -> 0 this cycle
module motoro3_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic nRst,
   input  logic pwmIn,
   output logic pwmS,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   pwmD;

   // Not touched by the capture clear: only nRst resets the chain.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         syncQ <= '0;
         pwmD  <= 1'b0;
      end else begin
         syncQ <= {syncQ[SYNC_STAGES-2:0], pwmIn};
         pwmD  <= pwmS;
      end
   end

   assign pwmS = syncQ[SYNC_STAGES-1];
   assign rise = pwmS & ~pwmD;
   assign fall = ~pwmS & pwmD;

endmodule

// File: rtl/motoro3_pwm_capture.sv
// rtl/motoro3_pwm_capture.sv - PWM on/off phase length capture with stuck-line detection
// Ports:
//   clk       in   system clock, 10 MHz
//   nRst      in   asynchronous active-low reset
//   pwmIn     in   PWM line, asynchronous to clk
//   capClr    in   synchronous clear, highest priority
//   onTime    out  last measured high length in cycles
//   offTime   out  last measured low length in cycles
//   capValid  out  one-cycle strobe, onTime/offTime updated
//   stuckHi   out  high phase reached CNT_MAX
//   stuckLo   out  low phase reached CNT_MAX
module motoro3_pwm_capture
   import motoro3_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             pwmIn,
   input  logic             capClr,
   output logic [CNT_W-1:0] onTime,
   output logic [CNT_W-1:0] offTime,
   output logic             capValid,
   output logic             stuckHi,
   output logic             stuckLo
);

   logic pwmS;
   logic rise;
   logic fall;

   motoro3_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) uSyncEdge (
      .clk   (clk),
      .nRst  (nRst),
      .pwmIn (pwmIn),
      .pwmS  (pwmS),
      .rise  (rise),
      .fall  (fall)
   );

   capState_t        state,    stateNxt;
   logic [CNT_W-1:0] hiCnt,    hiCntNxt;
   logic [CNT_W-1:0] loCnt,    loCntNxt;
   logic [CNT_W-1:0] hiLat,    hiLatNxt;
   logic [CNT_W-1:0] onNxt,    offNxt;
   logic             validNxt, stuckHiNxt, stuckLoNxt;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state    <= IDLE;
         hiCnt    <= '0;
         loCnt    <= '0;
         hiLat    <= '0;
         onTime   <= '0;
         offTime  <= '0;
         capValid <= 1'b0;
         stuckHi  <= 1'b0;
         stuckLo  <= 1'b0;
      end else begin
         state    <= stateNxt;
         hiCnt    <= hiCntNxt;
         loCnt    <= loCntNxt;
         hiLat    <= hiLatNxt;
         onTime   <= onNxt;
         offTime  <= offNxt;
         capValid <= validNxt;
         stuckHi  <= stuckHiNxt;
         stuckLo  <= stuckLoNxt;
      end
   end

   always_comb begin
      stateNxt   = state;
      hiCntNxt   = hiCnt;
      loCntNxt   = loCnt;
      hiLatNxt   = hiLat;
      onNxt      = onTime;
      offNxt     = offTime;
      validNxt   = 1'b0;
      stuckHiNxt = stuckHi;
      stuckLoNxt = stuckLo;

      if (capClr) begin
         stateNxt   = IDLE;
         hiCntNxt   = '0;
         loCntNxt   = '0;
         hiLatNxt   = '0;
         onNxt      = '0;
         offNxt     = '0;
         stuckHiNxt = 1'b0;
         stuckLoNxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // First rise only arms the measurement: the period before it is partial.
               if (rise) begin
                  hiCntNxt = CNT_ONE;
                  stateNxt = HIGH;
               end else begin
                  loCntNxt = satInc(loCnt);
                  if (loCnt == CNT_MAX_M1) begin
                     stuckLoNxt = 1'b1;
                     onNxt      = '0;
                     offNxt     = CNT_MAX;
                     validNxt   = 1'b1;
                     stateNxt   = LOW;
                  end
               end
            end
            HIGH: begin
               if (fall) begin
                  hiLatNxt   = hiCnt;
                  loCntNxt   = CNT_ONE;
                  stuckHiNxt = 1'b0;
                  stateNxt   = LOW;
               end else if (pwmS) begin
                  hiCntNxt = satInc(hiCnt);
                  // Only the step into saturation reports, so the pulse fires once.
                  if (hiCnt == CNT_MAX_M1) begin
                     stuckHiNxt = 1'b1;
                     onNxt      = CNT_MAX;
                     offNxt     = '0;
                     validNxt   = 1'b1;
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  onNxt      = hiLat;
                  offNxt     = loCnt;
                  validNxt   = 1'b1;
                  hiCntNxt   = CNT_ONE;
                  stuckLoNxt = 1'b0;
                  stateNxt   = HIGH;
               end else if (!pwmS) begin
                  loCntNxt = satInc(loCnt);
                  if (loCnt == CNT_MAX_M1) begin
                     stuckLoNxt = 1'b1;
                     onNxt      = '0;
                     offNxt     = CNT_MAX;
                     validNxt   = 1'b1;
                  end
               end
            end
            default: stateNxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// tb/tb_motoro3_pwm_capture.sv - self-checking bench for motoro3_pwm_capture
module tb_motoro3_pwm_capture;

   localparam int SYNC   = 2;
   localparam int CMAX   = 8191;
   localparam int M_IDLE = 0;
   localparam int M_HIGH = 1;
   localparam int M_LOW  = 2;

   logic        clk    = 1'b0;
   logic        nRst   = 1'b0;
   logic        pwmIn  = 1'b0;
   logic        capClr = 1'b0;
   logic [12:0] onTime;
   logic [12:0] offTime;
   logic        capValid;
   logic        stuckHi;
   logic        stuckLo;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   // Reference model state: line history plus unbounded run lengths.
   logic [7:0] hist   = '0;
   int         mode   = M_IDLE;
   int         hiRun  = 0;
   int         loRun  = 0;
   int         hiLast = 0;
   int         expOn  = 0;
   int         expOff = 0;
   bit         expValid = 1'b0;
   bit         expHi    = 1'b0;
   bit         expLo    = 1'b0;

   // Every report the DUT made, for the literal checks.
   int logOn[$];
   int logOff[$];
   bit logHi[$];
   bit logLo[$];

   motoro3_pwm_capture #(
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk      (clk),
      .nRst     (nRst),
      .pwmIn    (pwmIn),
      .capClr   (capClr),
      .onTime   (onTime),
      .offTime  (offTime),
      .capValid (capValid),
      .stuckHi  (stuckHi),
      .stuckLo  (stuckLo)
   );

   always #50 clk = ~clk;

   function automatic int clip(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic report(input int on, input int off);
      expOn    = on;
      expOff   = off;
      expValid = 1'b1;
   endtask

   initial begin : model
      bit s, d, rise, fall;
      forever begin
         @(posedge clk or negedge nRst);
         if (!nRst) begin
            hist = '0; mode = M_IDLE; hiRun = 0; loRun = 0; hiLast = 0;
            expOn = 0; expOff = 0; expValid = 1'b0; expHi = 1'b0; expLo = 1'b0;
         end else begin
            // Level seen by the capture logic is pwmIn delayed by the synchronizer depth.
            s = hist[SYNC-1];
            d = hist[SYNC];
            hist = {hist[6:0], pwmIn};
            rise = s & ~d;
            fall = ~s & d;
            expValid = 1'b0;
            if (capClr) begin
               mode = M_IDLE; hiRun = 0; loRun = 0; hiLast = 0;
               expOn = 0; expOff = 0; expHi = 1'b0; expLo = 1'b0;
            end else if (mode == M_IDLE) begin
               if (rise) begin
                  hiRun = 1; mode = M_HIGH;
               end else begin
                  loRun++;
                  if (loRun == CMAX) begin expLo = 1'b1; report(0, CMAX); mode = M_LOW; end
               end
            end else if (mode == M_HIGH) begin
               if (fall) begin
                  hiLast = clip(hiRun); loRun = 1; expHi = 1'b0; mode = M_LOW;
               end else if (s) begin
                  hiRun++;
                  if (hiRun == CMAX) begin expHi = 1'b1; report(CMAX, 0); end
               end
            end else begin
               if (rise) begin
                  report(hiLast, clip(loRun)); hiRun = 1; expLo = 1'b0; mode = M_HIGH;
               end else if (!s) begin
                  loRun++;
                  if (loRun == CMAX) begin expLo = 1'b1; report(0, CMAX); end
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         cycle++;
         vectors++;
         if ($isunknown({capValid, onTime, offTime, stuckHi, stuckLo}) ||
             capValid != expValid || int'(onTime) != expOn || int'(offTime) != expOff ||
             stuckHi != expHi || stuckLo != expLo) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got v=%0b on=%0d off=%0d hi=%0b lo=%0b, want v=%0b on=%0d off=%0d hi=%0b lo=%0b",
                     cycle, capValid, onTime, offTime, stuckHi, stuckLo,
                     expValid, expOn, expOff, expHi, expLo);
         end
         if (capValid === 1'b1) begin
            logOn.push_back(int'(onTime));
            logOff.push_back(int'(offTime));
            logHi.push_back(stuckHi);
            logLo.push_back(stuckLo);
         end
      end
   end

   task automatic drive(input bit lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pwmIn = lvl;
      end
   endtask

   task automatic clearLog();
      logOn.delete(); logOff.delete(); logHi.delete(); logLo.delete();
   endtask

   task automatic checkVal(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic checkPulse(input string name, input int idx, input int on, input int off,
                             input bit hi, input bit lo);
      vectors++;
      if (idx >= logOn.size()) begin
         miscompares++;
         $display("FAIL %s: report %0d missing, got %0d reports, want on=%0d off=%0d", name, idx, logOn.size(), on, off);
      end else if (logOn[idx] != on || logOff[idx] != off || logHi[idx] != hi || logLo[idx] != lo) begin
         miscompares++;
         $display("FAIL %s: got on=%0d off=%0d hi=%0b lo=%0b, want on=%0d off=%0d hi=%0b lo=%0b",
                  name, logOn[idx], logOff[idx], logHi[idx], logLo[idx], on, off, hi, lo);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkVal({name, " onTime"},   int'(onTime),   0);
      checkVal({name, " offTime"},  int'(offTime),  0);
      checkVal({name, " capValid"}, int'(capValid), 0);
      checkVal({name, " stuckHi"},  int'(stuckHi),  0);
      checkVal({name, " stuckLo"},  int'(stuckLo),  0);
   endtask

   initial begin : stimulus
      int n;
      bit lvl;

      repeat (3) @(negedge clk);
      checkAllZero("reset");
      nRst = 1'b1;

      // Steady 256/3839 wave: first period unreported.
      clearLog();
      drive(0, 100);
      repeat (4) begin drive(1, 256); drive(0, 3839); end
      checkVal("steady count", logOn.size(), 3);
      for (int i = 0; i < 3; i++) checkPulse("steady", i, 256, 3839, 0, 0);

      // 1/1 square wave.
      clearLog();
      repeat (20) begin drive(1, 1); drive(0, 1); end
      drive(0, 20);
      checkVal("square count", logOn.size(), 20);
      checkPulse("square first", 0, 256, 3839, 0, 0);
      for (int i = 1; i < 20; i++) checkPulse("square", i, 1, 1, 0, 0);

      // Stuck high, then recovery.
      clearLog();
      drive(1, 9000);
      drive(0, 100);
      checkVal("stuckHi after fall", int'(stuckHi), 0);
      drive(1, 10);
      drive(0, 10);
      checkVal("stuck-high count", logOn.size(), 3);
      checkPulse("pre stuck-high", 0, 1, 21, 0, 0);
      checkPulse("stuck-high", 1, CMAX, 0, 1, 0);
      checkPulse("after stuck-high", 2, CMAX, 100, 0, 0);

      // Stuck low from reset.
      nRst = 1'b0;
      drive(0, 3);
      clearLog();
      nRst = 1'b1;
      drive(0, 9000);
      checkVal("stuck-low count", logOn.size(), 1);
      checkPulse("stuck-low", 0, 0, CMAX, 0, 1);
      checkVal("stuckLo held", int'(stuckLo), 1);

      // 500/500 wave with a clear in mid-high.
      clearLog();
      repeat (2) begin drive(1, 500); drive(0, 500); end
      checkPulse("after stuck-low", 0, 0, CMAX, 0, 0);
      checkPulse("500 wave", 1, 500, 500, 0, 0);
      drive(1, 250);
      capClr = 1'b1;
      drive(1, 1);
      capClr = 1'b0;
      checkAllZero("capClr");
      clearLog();
      drive(1, 249); drive(0, 500); drive(1, 500); drive(0, 500);
      checkVal("after clr first rise silent", logOn.size(), 0);
      drive(1, 500); drive(0, 10);
      checkVal("after clr count", logOn.size(), 1);
      checkPulse("after clr", 0, 500, 500, 0, 0);

      // Asynchronous reset with a report in flight.
      drive(1, 500); drive(0, 500); drive(1, 1);
      @(posedge clk);
      #2 nRst = 1'b0;
      #1 checkAllZero("async reset");
      pwmIn = 1'b0;
      repeat (3) @(negedge clk);
      clearLog();
      nRst = 1'b1;
      drive(0, 100); drive(1, 500); drive(0, 500);
      checkVal("after reset first rise silent", logOn.size(), 0);
      drive(1, 500); drive(0, 10);
      checkVal("after reset count", logOn.size(), 1);
      checkPulse("after reset", 0, 500, 500, 0, 0);

      // Saturation boundary: CNT_MAX-1 is exact, CNT_MAX is stuck.
      clearLog();
      drive(1, CMAX - 1); drive(0, 5); drive(1, CMAX); drive(0, 5); drive(1, 3); drive(0, 3);
      checkPulse("boundary pre", 0, 500, 10, 0, 0);
      checkPulse("boundary max-1", 1, CMAX - 1, 5, 0, 0);
      checkPulse("boundary max", 2, CMAX, 0, 1, 0);
      checkPulse("boundary after", 3, CMAX, 5, 0, 0);

      // Random phases with occasional clears, checked by the model.
      lvl = 1'b0;
      for (int i = 0; i < 300; i++) begin
         lvl = ~lvl;
         n = $urandom_range(1, 30);
         if ($urandom_range(0, 24) == 0) begin
            capClr = 1'b1;
            drive(lvl, 1);
            capClr = 1'b0;
            if (n > 1) drive(lvl, n - 1);
         end else begin
            drive(lvl, n);
         end
      end
      drive(0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
